// File: rtl/perceptron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_scheduler
// Purpose  : Time-multiplexed evaluator for a layer of N_NEURONS binary-input
//            perceptrons sharing one add/compare datapath. Weights and
//            thresholds arrive at runtime over a valid/ready byte stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   ena        in   1          1 = advance, 0 = freeze all state
//   cfg_valid  in   1          cfg_data valid
//   cfg_ready  out  1          ready to accept cfg_data
//   cfg_data   in   W_WIDTH    weight or threshold byte
//   start      in   1          begin evaluation, samples in_vec
//   in_vec     in   N_INPUTS   binary input vector
//   busy       out  1          evaluation in progress
//   done       out  1          one-cycle pulse when out_vec is updated
//   loaded     out  1          complete weight set present
//   out_vec    out  N_NEURONS  neuron outputs, bit k = neuron k
// Configuration macro
//   PSCHED_CONTINUOUS_EN : DONE re-enters EVAL (re-latching in_vec) instead
//                          of IDLE until a config byte is offered.
// ============================================================================
module perceptron_scheduler #(
   parameter int N_NEURONS = 8,
   parameter int N_INPUTS  = 8,
   parameter int W_WIDTH   = 8,
   parameter int ACC_WIDTH = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [W_WIDTH-1:0]   cfg_data,
   input  logic                 start,
   input  logic [N_INPUTS-1:0]  in_vec,
   output logic                 busy,
   output logic                 done,
   output logic                 loaded,
   output logic [N_NEURONS-1:0] out_vec
);

   localparam int DEPTH  = N_NEURONS * (N_INPUTS + 1);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int I_W    = $clog2(N_INPUTS + 1);
   localparam int K_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int STRIDE = N_INPUTS + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EVAL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic                   loaded_q, loaded_d;
   logic [N_NEURONS-1:0]   out_vec_q, out_vec_d;
   logic [N_NEURONS-1:0]   res_q, res_d;
   logic [N_INPUTS-1:0]    in_sh_q, in_sh_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [I_W-1:0]         i_q, i_d;
   logic [K_W-1:0]         k_q, k_d;
   logic [PTR_W-1:0]       base_q, base_d;
   logic [W_WIDTH-1:0]     ram_q [0:DEPTH-1];

   logic                   start_go;
   logic                   accept;
   logic                   wr_en;
   logic [PTR_W-1:0]       rd_addr;
   logic [W_WIDTH-1:0]     rd_data;
   logic                   last_in;
   logic                   last_nrn;
   logic                   fire;
   logic [ACC_WIDTH-1:0]   addend;
   logic [N_NEURONS:0]     res_wide;
   logic [N_INPUTS:0]      rot_wide;

   // An honoured start takes priority over a byte offered in the same cycle.
   assign start_go  = (state_q == S_IDLE) && start && loaded_q && ena;
   assign cfg_ready = ((state_q == S_IDLE) && !start_go) || (state_q == S_LOAD);
   assign accept    = cfg_valid && cfg_ready && ena;

   // Neuron k occupies STRIDE consecutive bytes: weights, then threshold at
   // offset N_INPUTS, which is exactly where i_q sits on the compare cycle.
   assign rd_addr  = base_q + PTR_W'(i_q);
   assign rd_data  = ram_q[rd_addr];
   assign last_in  = (i_q == I_W'(N_INPUTS));
   assign last_nrn = (k_q == K_W'(N_NEURONS - 1));
   assign fire     = (acc_q > ACC_WIDTH'(rd_data));
   assign addend   = in_sh_q[0] ? ACC_WIDTH'(rd_data) : '0;

   // Results shift in from the top so neuron k lands on bit k after the last
   // compare; the latched inputs rotate so they are intact for every neuron.
   assign res_wide = {fire, res_q} >> 1;
   assign rot_wide = {in_sh_q[0], in_sh_q} >> 1;

   assign busy    = (state_q == S_EVAL);
   assign loaded  = loaded_q;
   assign out_vec = out_vec_q;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      loaded_d  = loaded_q;
      out_vec_d = out_vec_q;
      res_d     = res_q;
      in_sh_d   = in_sh_q;
      acc_d     = acc_q;
      i_d       = i_q;
      k_d       = k_q;
      base_d    = base_q;
      wr_en     = 1'b0;
      done      = 1'b0;

      if (ena) begin
         unique case (state_q)
            S_IDLE, S_LOAD: begin
               if (start_go) begin
                  state_d = S_EVAL;
                  in_sh_d = in_vec;
                  acc_d   = '0;
                  i_d     = '0;
                  k_d     = '0;
                  base_d  = '0;
               end else if (accept) begin
                  wr_en = 1'b1;
                  if (ptr_q == PTR_W'(DEPTH - 1)) begin
                     ptr_d    = '0;
                     loaded_d = 1'b1;
                     state_d  = S_IDLE;
                  end else begin
                     ptr_d    = ptr_q + PTR_W'(1);
                     loaded_d = 1'b0;
                     state_d  = S_LOAD;
                  end
               end
            end
            S_EVAL: begin
               if (!last_in) begin
                  acc_d   = acc_q + addend;
                  in_sh_d = rot_wide[N_INPUTS-1:0];
                  i_d     = i_q + I_W'(1);
               end else begin
                  res_d = res_wide[N_NEURONS-1:0];
                  acc_d = '0;
                  i_d   = '0;
                  if (last_nrn) begin
                     out_vec_d = res_wide[N_NEURONS-1:0];
                     state_d   = S_DONE;
                  end else begin
                     k_d    = k_q + K_W'(1);
                     base_d = base_q + PTR_W'(STRIDE);
                  end
               end
            end
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
`ifdef PSCHED_CONTINUOUS_EN
               // A pending config byte breaks the loop back to IDLE.
               if (!(!start && cfg_valid) && loaded_q) begin
                  state_d = S_EVAL;
                  in_sh_d = in_vec;
                  acc_d   = '0;
                  i_d     = '0;
                  k_d     = '0;
                  base_d  = '0;
               end
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         loaded_q  <= 1'b0;
         out_vec_q <= '0;
         res_q     <= '0;
         in_sh_q   <= '0;
         acc_q     <= '0;
         i_q       <= '0;
         k_q       <= '0;
         base_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         loaded_q  <= loaded_d;
         out_vec_q <= out_vec_d;
         res_q     <= res_d;
         in_sh_q   <= in_sh_d;
         acc_q     <= acc_d;
         i_q       <= i_d;
         k_q       <= k_d;
         base_q    <= base_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++) begin
            ram_q[j] <= '0;
         end
      end else if (wr_en) begin
         ram_q[ptr_q] <= cfg_data;
      end
   end

endmodule
`default_nettype wire
